// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: address geometry,
// controller state encoding and address field slicing helpers.
package cache_pkg;

  localparam int ADDR_BITS        = 32;
  localparam int WORD_BITS        = 32;
  localparam int WORD_BYTES_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE,
    WB_RD,
    WB_WR,
    FILL,
    FILL_ST
  } state_t;

  // Index bits are whatever remains once tag, word offset and byte offset are taken.
  function automatic int line_index_width(input int tag_bits, input int line_words_width);
    return ADDR_BITS - tag_bits - line_words_width - WORD_BYTES_WIDTH;
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr,
                                                    input int tag_bits);
    return addr >> (ADDR_BITS - tag_bits);
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr,
                                                      input int tag_bits,
                                                      input int line_words_width);
    int idx_w;
    idx_w = line_index_width(tag_bits, line_words_width);
    return (addr >> (line_words_width + WORD_BYTES_WIDTH)) & ~({ADDR_BITS{1'b1}} << idx_w);
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_offset(input logic [ADDR_BITS-1:0] addr,
                                                       input int line_words_width);
    return (addr >> WORD_BYTES_WIDTH) & ~({ADDR_BITS{1'b1}} << line_words_width);
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for the direct-mapped cache array.
// Serves CPU loads/stores, writes back dirty victims and fills lines over a
// one-word-at-a-time memory handshake. The array is clocked on negedge, so
// an address presented after a posedge yields array outputs by the next posedge.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_BITS         = 22,
  parameter int LINE_WORDS       = 4,
  parameter int LINE_WORDS_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WORD_BITS-1:0] cpu_din,
  output logic                 cpu_ack,
  output logic [WORD_BITS-1:0] cpu_dout,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic                 cache_invalid,
  output logic [WORD_BITS-1:0] cache_din,
  input  logic                 cache_hit,
  input  logic [WORD_BITS-1:0] cache_dout,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_dout,
  input  logic [WORD_BITS-1:0] mem_din,
  input  logic                 mem_ack
);

  localparam int IDX_W = line_index_width(TAG_BITS, LINE_WORDS_WIDTH);
  localparam logic [LINE_WORDS_WIDTH-1:0] K_LAST = LINE_WORDS_WIDTH'(LINE_WORDS - 1);

  state_t                      state;
  logic [LINE_WORDS_WIDTH-1:0] k;
  logic [ADDR_BITS-1:0]        req_addr;
  logic                        req_we;
  logic [WORD_BITS-1:0]        req_din;
  logic [WORD_BITS-1:0]        fill_buf;
  logic [TAG_BITS-1:0]         victim_tag;

  logic [TAG_BITS-1:0]         req_tag;
  logic [IDX_W-1:0]            req_index;
  logic [LINE_WORDS_WIDTH-1:0] req_offset;
  logic [LINE_WORDS_WIDTH-1:0] addr_off;

  assign cache_invalid = 1'b0;

  // Split the latched request address into its tag/index/offset fields.
  always_comb begin
    req_tag    = TAG_BITS'(addr_tag(req_addr, TAG_BITS));
    req_index  = IDX_W'(addr_index(req_addr, TAG_BITS, LINE_WORDS_WIDTH));
    req_offset = LINE_WORDS_WIDTH'(addr_offset(req_addr, LINE_WORDS_WIDTH));
  end

  // Array address follows the request, with the word offset taken from k while walking a line.
  always_comb begin
    addr_off = req_offset;
    if (state inside {WB_RD, WB_WR, FILL, FILL_ST}) begin
      addr_off = k;
    end
    cache_addr = {req_tag, req_index, addr_off, {WORD_BYTES_WIDTH{1'b0}}};
    cache_din  = (state == FILL_ST) ? fill_buf : req_din;
  end

  // Control FSM with registered CPU, memory and array strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_dout    <= '0;
      cache_store <= 1'b0;
      cache_edit  <= 1'b0;
      req_addr    <= '0;
      req_we      <= 1'b0;
      req_din     <= '0;
      fill_buf    <= '0;
      victim_tag  <= '0;
    end else begin
      cpu_ack     <= 1'b0;
      cache_store <= 1'b0;
      cache_edit  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr <= cpu_addr;
            req_we   <= cpu_we;
            req_din  <= cpu_din;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cache_hit) begin
            if (req_we) begin
              cache_edit <= 1'b1;
              state      <= WRITE;
            end else begin
              cpu_dout <= cache_dout;
              cpu_ack  <= 1'b1;
              state    <= IDLE;
            end
          end else if (cache_valid && cache_dirty) begin
            victim_tag <= cache_tag;
            k          <= '0;
            state      <= WB_RD;
          end else begin
            k        <= '0;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_index, {LINE_WORDS_WIDTH{1'b0}}, {WORD_BYTES_WIDTH{1'b0}}};
            state    <= FILL;
          end
        end
        WRITE: begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        // The array has registered word k by now; capture it for the write.
        WB_RD: begin
          mem_cs   <= 1'b1;
          mem_we   <= 1'b1;
          mem_addr <= {victim_tag, req_index, k, {WORD_BYTES_WIDTH{1'b0}}};
          mem_dout <= cache_dout;
          state    <= WB_WR;
        end
        // Last write-back word rolls straight into the first fill read, keeping mem_cs high.
        WB_WR: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (k == K_LAST) begin
              k        <= '0;
              mem_addr <= {req_tag, req_index, {LINE_WORDS_WIDTH{1'b0}}, {WORD_BYTES_WIDTH{1'b0}}};
              state    <= FILL;
            end else begin
              k      <= k + 1'b1;
              mem_cs <= 1'b0;
              state  <= WB_RD;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            fill_buf    <= mem_din;
            mem_cs      <= 1'b0;
            cache_store <= 1'b1;
            state       <= FILL_ST;
          end
        end
        FILL_ST: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= LOOKUP;
          end else begin
            k        <= k + 1'b1;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_index, k + 1'b1, {WORD_BYTES_WIDTH{1'b0}}};
            state    <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a negedge array model and a
// delay-configurable word memory.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int EV_MRD   = 0;
  localparam int EV_MWR   = 1;
  localparam int EV_STORE = 2;
  localparam int EV_EDIT  = 3;
  localparam int EV_ACK   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [31:0] cache_addr, cache_din, cache_dout;
  logic        cache_store, cache_edit, cache_invalid;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [21:0] cache_tag;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_dout, mem_din;

  always #5 clk = ~clk;

  cache_ctrl #(.TAG_BITS(22), .LINE_WORDS(4), .LINE_WORDS_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
    .cache_invalid(cache_invalid), .cache_din(cache_din),
    .cache_hit(cache_hit), .cache_dout(cache_dout), .cache_valid(cache_valid),
    .cache_dirty(cache_dirty), .cache_tag(cache_tag),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
    int          lat;
    string       name;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          rd_delay = 0;
  int          wr_delay = 0;
  logic [31:0] mem_store [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      EV_MRD:   return "mem_rd";
      EV_MWR:   return "mem_wr";
      EV_STORE: return "store";
      EV_EDIT:  return "edit";
      default:  return "ack";
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input bit chk_data, input int lat, input string name);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    e.chk_data = chk_data; e.lat = lat; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_fill(input string tag, input logic [31:0] base,
                          input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      push(EV_MRD, base + 32'(4 * i), 32'h0, 1'b0, -1, $sformatf("%s_rd%0d", tag, i));
      push(EV_STORE, base + 32'(4 * i), w[i], 1'b1, -1, $sformatf("%s_st%0d", tag, i));
    end
  endtask

  task automatic exp_wb(input string tag, input logic [31:0] base,
                        input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++)
      push(EV_MWR, base + 32'(4 * i), w[i], 1'b1, -1, $sformatf("%s_wb%0d", tag, i));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input int lat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got addr=%h data=%h, expected no event", kname(kind), addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || (kind != EV_ACK && e.addr !== addr) ||
        (e.chk_data && e.data !== data) || (e.lat >= 0 && e.lat != lat)) begin
      errors++;
      $display("FAIL %s: got %s addr=%h data=%h lat=%0d, expected %s addr=%h data=%h lat=%0d",
               e.name, kname(kind), addr, data, lat, kname(e.kind), e.addr, e.data, e.lat);
    end
  endtask

  // Cache array model: writes and reads on negedge, outputs valid by the next posedge.
  logic [31:0] arr_data [64][4];
  logic [21:0] arr_tag [64];
  bit          arr_valid [64];
  bit          arr_dirty [64];
  initial begin
    int unsigned idx, off;
    for (int i = 0; i < 64; i++) begin
      arr_valid[i] = 0; arr_dirty[i] = 0; arr_tag[i] = '0;
      for (int j = 0; j < 4; j++) arr_data[i][j] = '0;
    end
    cache_hit = 0; cache_dout = '0; cache_valid = 0; cache_dirty = 0; cache_tag = '0;
    forever begin
      @(negedge clk);
      idx = 32'(cache_addr[9:4]);
      off = 32'(cache_addr[3:2]);
      if (cache_store) begin
        arr_data[idx][off] = cache_din;
        arr_tag[idx] = cache_addr[31:10];
        arr_valid[idx] = 1;
        arr_dirty[idx] = 0;
      end
      if (cache_edit) begin
        arr_data[idx][off] = cache_din;
        arr_dirty[idx] = 1;
      end
      cache_dout  = arr_data[idx][off];
      cache_tag   = arr_tag[idx];
      cache_valid = arr_valid[idx];
      cache_dirty = arr_dirty[idx];
      cache_hit   = arr_valid[idx] && (arr_tag[idx] == cache_addr[31:10]);
    end
  end

  // Memory model: acks after a configurable wait and checks request stability meanwhile.
  initial begin
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] s_addr, s_dout;
    logic        s_we;
    mem_ack = 0; mem_din = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0;
      if (rst || !mem_cs) begin
        if (!rst && busy) begin
          checks++; errors++;
          $display("FAIL mem_cs_dropped: got mem_cs=0 before ack, expected 1 (addr %h)", s_addr);
        end
        busy = 0; cnt = 0;
      end else begin
        if (!busy) begin
          busy = 1; cnt = 0; s_addr = mem_addr; s_we = mem_we; s_dout = mem_dout;
        end else begin
          checks++;
          if (mem_addr !== s_addr || mem_we !== s_we || (s_we && mem_dout !== s_dout)) begin
            errors++;
            $display("FAIL mem_hold: got addr=%h we=%b dout=%h, expected addr=%h we=%b dout=%h",
                     mem_addr, mem_we, mem_dout, s_addr, s_we, s_dout);
          end
        end
        if (cnt >= (mem_we ? wr_delay : rd_delay)) begin
          mem_ack = 1;
          if (mem_we) mem_store[mem_addr] = mem_dout;
          else mem_din = mem_store.exists(mem_addr) ? mem_store[mem_addr] : (32'hC0DE_0000 | mem_addr);
          busy = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every DUT output event is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_cs && mem_ack) observe(mem_we ? EV_MWR : EV_MRD, mem_addr, mem_dout, -1);
        if (cache_store) observe(EV_STORE, cache_addr, cache_din, -1);
        if (cache_edit) observe(EV_EDIT, cache_addr, cache_din, -1);
        if (cpu_ack) observe(EV_ACK, 32'h0, cpu_dout, cyc - accept_cyc);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] din);
    bit done = 0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    @(posedge clk); #1;
    accept_cyc = cyc;
    for (int n = 0; n < 200 && !done; n++) begin
      if (cpu_ack) done = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL req_timeout: got no cpu_ack for addr %h within 200 cycles, expected ack", addr);
    end
    cpu_req = 0;
  endtask

  initial begin
    bit found;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    mem_store[32'h0000_0040] = 32'h11;
    mem_store[32'h0000_0044] = 32'h22;
    mem_store[32'h0000_0048] = 32'h33;
    mem_store[32'h0000_004C] = 32'h44;
    mem_store[32'h0040_0040] = 32'h55;
    mem_store[32'h0040_0044] = 32'h66;
    mem_store[32'h0040_0048] = 32'h77;
    mem_store[32'h0040_004C] = 32'h88;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    chk("rst_cpu_dout", cpu_dout, 32'h0);
    chk("rst_mem_cs", 32'(mem_cs), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_dout", mem_dout, 32'h0);
    chk("rst_cache_store", 32'(cache_store), 32'h0);
    chk("rst_cache_edit", 32'(cache_edit), 32'h0);
    chk("cache_invalid", 32'(cache_invalid), 32'h0);
    rst = 0;

    // Cold miss fill of line 0x40.
    exp_fill("t1", 32'h40, 32'h11, 32'h22, 32'h33, 32'h44);
    push(EV_ACK, 32'h0, 32'h11, 1'b1, -1, "t1_ack");
    do_req(1'b0, 32'h0000_0040, 32'h0);

    // Load hit, one-cycle latency.
    push(EV_ACK, 32'h0, 32'h33, 1'b1, 1, "t2_ack");
    do_req(1'b0, 32'h0000_0048, 32'h0);

    // Store hit, two-cycle latency with one edit.
    push(EV_EDIT, 32'h44, 32'hDEAD_BEEF, 1'b1, -1, "t3_edit");
    push(EV_ACK, 32'h0, 32'h0, 1'b0, 2, "t3_ack");
    do_req(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);

    // Conflict miss with dirty victim: write-back then fill.
    exp_wb("t4", 32'h40, 32'h11, 32'hDEAD_BEEF, 32'h33, 32'h44);
    exp_fill("t4", 32'h0040_0040, 32'h55, 32'h66, 32'h77, 32'h88);
    push(EV_ACK, 32'h0, 32'h55, 1'b1, -1, "t4_ack");
    do_req(1'b0, 32'h0040_0040, 32'h0);

    // Slow memory reads during fill.
    rd_delay = 5;
    exp_fill("t5", 32'h80, 32'hC0DE_0080, 32'hC0DE_0084, 32'hC0DE_0088, 32'hC0DE_008C);
    push(EV_ACK, 32'h0, 32'hC0DE_0080, 1'b1, -1, "t5_ack");
    do_req(1'b0, 32'h0000_0080, 32'h0);
    rd_delay = 0;

    // Dirty the tag-0x1000 line again.
    push(EV_EDIT, 32'h0040_0044, 32'hCAFE_F00D, 1'b1, -1, "t6_edit");
    push(EV_ACK, 32'h0, 32'h0, 1'b0, 2, "t6_ack");
    do_req(1'b1, 32'h0040_0044, 32'hCAFE_F00D);

    // Reset while the first write-back word is outstanding.
    wr_delay = 1000;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040; cpu_din = '0;
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(posedge clk); #1;
      if (mem_cs && mem_we) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t7_reach_wb_wr: got no mem write request within 30 cycles, expected one");
    end
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    chk("t7_state", 32'(dut.state), 32'(IDLE));
    chk("t7_mem_cs", 32'(mem_cs), 32'h0);
    chk("t7_cpu_ack", 32'(cpu_ack), 32'h0);
    chk("t7_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 0; wr_delay = 0;

    // Request after reset is serviced normally.
    exp_wb("t8", 32'h0040_0040, 32'h55, 32'hCAFE_F00D, 32'h77, 32'h88);
    exp_fill("t8", 32'h40, 32'h11, 32'hDEAD_BEEF, 32'h33, 32'h44);
    push(EV_ACK, 32'h0, 32'h11, 1'b1, -1, "t8_ack");
    do_req(1'b0, 32'h0000_0040, 32'h0);

    for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events outstanding, expected 0 (next %s)", exp_q.size(), exp_q[0].name);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
